// File: rtl/node_phase_scheduler.sv
// N-node Verlet / constraint-relaxation phase sequencer for the cloth-simulation core.
// One frame: a Verlet strobe per node, CONSTRAINT_ITERS sweeps of constraint strobes, one done pulse.
module node_phase_scheduler #(
    parameter int NODES            = 5,
    parameter int CONSTRAINT_ITERS = 3,
    parameter int FRAME_W          = 32,
    localparam int SLOT_W = (NODES > 1) ? $clog2(NODES) : 1,
    localparam int ITER_W = (CONSTRAINT_ITERS > 1) ? $clog2(CONSTRAINT_ITERS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hold,
    output logic [NODES-1:0]   verlet_en,
    output logic [NODES-1:0]   constraint_en,
    output logic               busy,
    output logic               done,
    output logic [ITER_W-1:0]  iter,
    output logic [FRAME_W-1:0] frame_count
);

    localparam logic [1:0] StIdle       = 2'd0;
    localparam logic [1:0] StVerlet     = 2'd1;
    localparam logic [1:0] StConstraint = 2'd2;
    localparam logic [1:0] StDone       = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               slot_last;
    logic               iter_last;
    logic [NODES-1:0]   slot_onehot;

    assign slot_last = (slot_q == SLOT_W'(NODES - 1));
    assign iter_last = (int'(iter_q) == CONSTRAINT_ITERS - 1);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        iter_d  = iter_q;
        frame_d = frame_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StVerlet;
                    slot_d  = '0;
                    iter_d  = '0;
                end
            end
            StVerlet: begin
                if (!hold) begin
                    if (slot_last) begin
                        slot_d  = '0;
                        iter_d  = '0;
                        state_d = (CONSTRAINT_ITERS > 0) ? StConstraint : StDone;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            StConstraint: begin
                if (!hold) begin
                    if (slot_last) begin
                        slot_d = '0;
                        if (iter_last) begin
                            state_d = StDone;
                        end else begin
                            iter_d = iter_q + ITER_W'(1);
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                iter_d  = '0;
                frame_d = frame_q + FRAME_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            slot_q  <= '0;
            iter_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            iter_q  <= iter_d;
            frame_q <= frame_d;
        end
    end

    // hold masks the strobes combinationally so a stalled slot never fires twice
    always_comb begin
        slot_onehot = '0;
        for (int i = 0; i < NODES; i++) begin
            slot_onehot[i] = (slot_q == SLOT_W'(i));
        end
        verlet_en     = (state_q == StVerlet && !hold) ? slot_onehot : '0;
        constraint_en = (state_q == StConstraint && !hold) ? slot_onehot : '0;
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        iter          = (state_q == StConstraint) ? iter_q : '0;
        frame_count   = frame_q;
    end

endmodule

// File: tb/tb_node_phase_scheduler.sv
// Self-checking bench: two scheduler configurations checked cycle by cycle against a
// flat "position in the frame's strobe list" reference model, with randomized hold and start.
module tb_node_phase_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic a_start, a_hold, b_start, b_hold;

    logic [4:0]  a_ven, a_cen;
    logic        a_busy, a_done;
    logic [1:0]  a_iter;
    logic [31:0] a_fc;

    logic [7:0]  b_ven, b_cen;
    logic        b_busy, b_done;
    logic [0:0]  b_iter;
    logic [1:0]  b_fc;

    int n_checks = 0;
    int n_fail   = 0;
    bit checks_on = 1'b0;
    int exp_frames_a = 0;
    int exp_frames_b = 0;

    always #5 clk = ~clk;

    node_phase_scheduler u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (a_start),
        .hold          (a_hold),
        .verlet_en     (a_ven),
        .constraint_en (a_cen),
        .busy          (a_busy),
        .done          (a_done),
        .iter          (a_iter),
        .frame_count   (a_fc)
    );

    node_phase_scheduler #(
        .NODES            (8),
        .CONSTRAINT_ITERS (0),
        .FRAME_W          (2)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (b_start),
        .hold          (b_hold),
        .verlet_en     (b_ven),
        .constraint_en (b_cen),
        .busy          (b_busy),
        .done          (b_done),
        .iter          (b_iter),
        .frame_count   (b_fc)
    );

    // Enables of each instance must be one-hot or zero every cycle.
    always @(negedge clk) begin
        #2;
        if (checks_on) begin
            n_checks++;
            if (!$onehot0({a_ven, a_cen})) begin
                n_fail++;
                $display("FAIL onehot_a: got %b_%b required one-hot or zero", a_ven, a_cen);
            end
            n_checks++;
            if (!$onehot0({b_ven, b_cen})) begin
                n_fail++;
                $display("FAIL onehot_b: got %b_%b required one-hot or zero", b_ven, b_cen);
            end
        end
    end

    task automatic set_in(input bit sel, input logic st, input logic hd);
        if (sel) begin
            b_start = st;
            b_hold  = hd;
        end else begin
            a_start = st;
            a_hold  = hd;
        end
    endtask

    task automatic get_obs(input bit sel, output logic [7:0] ven, output logic [7:0] cen,
                           output logic busy, output logic done, output logic [31:0] it,
                           output logic [31:0] fc);
        if (sel) begin
            ven = b_ven; cen = b_cen; busy = b_busy; done = b_done;
            it = {31'b0, b_iter}; fc = {30'b0, b_fc};
        end else begin
            ven = {3'b0, a_ven}; cen = {3'b0, a_cen}; busy = a_busy; done = a_done;
            it = {30'b0, a_iter}; fc = a_fc;
        end
    endtask

    // n IDLE cycles with start low and random hold; everything but frame_count reads zero.
    task automatic idle_cycles(input bit sel, input int n);
        logic [7:0]  ven, cen;
        logic        busy, done;
        logic [31:0] it, fc, e_fc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            set_in(sel, 1'b0, 1'($urandom_range(0, 1)));
            #1;
            get_obs(sel, ven, cen, busy, done, it, fc);
            e_fc = sel ? 32'(exp_frames_b % 4) : 32'(exp_frames_a);
            n_checks++;
            if ({ven, cen, busy, done, it} !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: got ven=%h cen=%h busy=%b done=%b iter=%0d required all 0",
                         sel, ven, cen, busy, done, it);
            end
            n_checks++;
            if (fc !== e_fc) begin
                n_fail++;
                $display("FAIL idle_frame_count[%0d]: got %0d required %0d", sel, fc, e_fc);
            end
        end
    endtask

    // One frame: IDLE cycle with start, then the model walks the strobe list
    // (NODES verlet slots, NODES*ITERS constraint slots, then done), pausing on hold.
    // mode 0: no hold, 1: random hold, 2: hold 2 cycles at iter 1 / constraint slot 2.
    task automatic run_frame(input bit sel, input int mode, input bit keep_start,
                             output int done_cycle, output int hold_cycles);
        int n_nodes, n_iter, total, pos, cyc, held, k;
        bit h;
        logic [7:0]  ven, cen, e_ven, e_cen;
        logic        busy, done;
        logic [31:0] it, fc, e_it, e_fc;
        n_nodes = sel ? 8 : 5;
        n_iter  = sel ? 0 : 3;
        total   = n_nodes + n_nodes * n_iter;

        @(negedge clk);
        set_in(sel, 1'b1, 1'($urandom_range(0, 1)));
        #1;
        get_obs(sel, ven, cen, busy, done, it, fc);
        e_fc = sel ? 32'(exp_frames_b % 4) : 32'(exp_frames_a);
        n_checks++;
        if ({ven, cen, busy, done, it} !== '0) begin
            n_fail++;
            $display("FAIL start_idle[%0d]: got ven=%h cen=%h busy=%b done=%b iter=%0d required all 0",
                     sel, ven, cen, busy, done, it);
        end
        n_checks++;
        if (fc !== e_fc) begin
            n_fail++;
            $display("FAIL frame_count[%0d]: got %0d required %0d", sel, fc, e_fc);
        end

        pos = 0; cyc = 0; held = 0; hold_cycles = 0; done_cycle = -1;
        while (pos <= total) begin
            @(negedge clk);
            cyc++;
            h = 1'b0;
            if (mode == 1) h = ($urandom_range(0, 3) == 0);
            else if (mode == 2) h = (pos == 12 && held < 2);
            if (h) held++;
            if (h && pos < total) hold_cycles++;
            set_in(sel, keep_start ? 1'b1 : (pos == total ? 1'b0 : 1'($urandom_range(0, 1))), h);
            #1;
            get_obs(sel, ven, cen, busy, done, it, fc);
            e_ven = '0; e_cen = '0; e_it = '0;
            if (pos < n_nodes) begin
                if (!h) e_ven[pos] = 1'b1;
            end else if (pos < total) begin
                k = pos - n_nodes;
                e_it = 32'(k / n_nodes);
                if (!h) e_cen[k % n_nodes] = 1'b1;
            end
            n_checks++;
            if ({ven, cen} !== {e_ven, e_cen}) begin
                n_fail++;
                $display("FAIL enables[%0d] cyc %0d: got ven=%h cen=%h required ven=%h cen=%h",
                         sel, cyc, ven, cen, e_ven, e_cen);
            end
            n_checks++;
            if (busy !== 1'b1 || done !== (pos == total)) begin
                n_fail++;
                $display("FAIL busy_done[%0d] cyc %0d: got busy=%b done=%b required busy=1 done=%b",
                         sel, cyc, busy, done, pos == total);
            end
            n_checks++;
            if (it !== e_it) begin
                n_fail++;
                $display("FAIL iter[%0d] cyc %0d: got %0d required %0d", sel, cyc, it, e_it);
            end
            if (pos == total) done_cycle = cyc;
            if (!h || pos == total) pos++;
        end
        if (sel) exp_frames_b++;
        else exp_frames_a++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({a_ven, a_cen, a_busy, a_done, a_iter, a_fc, b_ven, b_cen, b_busy, b_done, b_iter, b_fc} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got a=%h/%h/%b/%b/%0d/%0d b=%h/%h/%b/%b/%0d/%0d required all 0",
                     a_ven, a_cen, a_busy, a_done, a_iter, a_fc, b_ven, b_cen, b_busy, b_done, b_iter, b_fc);
        end
        @(negedge clk);
        reset = 1'b0;
        checks_on = 1'b1;
        idle_cycles(1'b0, 2);
    endtask

    task automatic test_nominal();
        int dc, hc;
        run_frame(1'b0, 0, 1'b0, dc, hc);
        n_checks++;
        if (dc != 21) begin
            n_fail++;
            $display("FAIL nominal_done_cycle: got %0d required 21", dc);
        end
        idle_cycles(1'b0, 1);
    endtask

    task automatic test_hold_directed();
        int dc, hc;
        run_frame(1'b0, 2, 1'b0, dc, hc);
        n_checks++;
        if (dc != 23) begin
            n_fail++;
            $display("FAIL hold_done_cycle: got %0d required 23", dc);
        end
        idle_cycles(1'b0, 2);
    endtask

    task automatic test_hold_random();
        int dc, hc;
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b0, 1, 1'b0, dc, hc);
            n_checks++;
            if (dc != 21 + hc) begin
                n_fail++;
                $display("FAIL random_hold_done_cycle: got %0d required %0d", dc, 21 + hc);
            end
            idle_cycles(1'b0, $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        int dc, hc;
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 0, 1'b1, dc, hc);
            n_checks++;
            if (dc != 21) begin
                n_fail++;
                $display("FAIL b2b_done_cycle: got %0d required 21", dc);
            end
        end
        idle_cycles(1'b0, 2);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b0);
        repeat (10) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0);
        end
        #1;
        n_checks++;
        if (a_cen === 5'b0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_precondition: got cen=%b busy=%b required nonzero cen, busy=1", a_cen, a_busy);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a_ven, a_cen, a_busy, a_done, a_iter, a_fc, b_ven, b_cen, b_busy, b_done, b_iter, b_fc} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got a=%h/%h/%b/%b/%0d/%0d b=%h/%h/%b/%b/%0d/%0d required all 0",
                     a_ven, a_cen, a_busy, a_done, a_iter, a_fc, b_ven, b_cen, b_busy, b_done, b_iter, b_fc);
        end
        exp_frames_a = 0;
        exp_frames_b = 0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        idle_cycles(1'b0, 5);
        idle_cycles(1'b1, 2);
    endtask

    task automatic test_no_constraint_wrap();
        int dc, hc;
        run_frame(1'b1, 0, 1'b0, dc, hc);
        n_checks++;
        if (dc != 9) begin
            n_fail++;
            $display("FAIL noconstraint_done_cycle: got %0d required 9", dc);
        end
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b1, 1, 1'b0, dc, hc);
            n_checks++;
            if (dc != 9 + hc) begin
                n_fail++;
                $display("FAIL noconstraint_hold_done_cycle: got %0d required %0d", dc, 9 + hc);
            end
        end
        idle_cycles(1'b1, 2);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold_directed();
        test_hold_random();
        test_back_to_back();
        test_async_reset();
        test_no_constraint_wrap();
        checks_on = 1'b0;
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
